// File: rtl/spi_slv.sv
// SPI mode-0 target: oversamples sck/cs/mosi and turns command/data bytes into hs_read/hs_write requests.
// Define SPI_SLV_AUTOINC_EN for burst access with auto-incrementing address.
module spi_slv #(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              cs_ni,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic              hs_read_o,
    output logic              hs_write_o,
    output logic [ADDR_W-1:0] hs_addr_o,
    output logic [7:0]        hs_data_o,
    input  logic              hs_ready_i,
    input  logic [7:0]        hs_data_i,
    output logic              ovr_o
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDUMMY, S_RDATA} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
    logic                   sck_rise, sck_fall, cs_sync, mosi_s;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             rx_q;
    logic [7:0]             tx_q, rx_byte, tx_load;
    logic                   byte_done, load_tx, cmd_done, wr_byte, rd_byte;
    logic                   hs_read_q, hs_read_d, hs_write_q, hs_write_d;
    logic [ADDR_W-1:0]      hs_addr_q, hs_addr_d, addr_q, addr_d;
    logic [7:0]             hs_data_q, hs_data_d, rbuf_q, rbuf_d;
    logic                   rvalid_q, rvalid_d, rd_want_q, rd_want_d;
    logic                   stale_q, stale_d, ovr_q, ovr_d;
    logic                   busy, wr_go, reload;
`ifndef SPI_SLV_AUTOINC_EN
    logic                   first_q, first_d;
`endif

    // NOTE: cs synchronizer resets to 1 (deselected) so reset release never looks like a frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck_i};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_ni};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign sck_rise  = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
    assign sck_fall  = ~sck_q[SYNC_STAGES-2] & sck_q[SYNC_STAGES-1];
    assign cs_sync   = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign rx_byte   = {rx_q, mosi_s};
    assign byte_done = ~cs_sync & sck_rise & (bit_cnt_q == 3'd7);
    assign busy      = hs_read_q | hs_write_q;

    // The fall right after a byte boundary does not shift, so a freshly loaded MSB reaches the host.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
        end else if (cs_sync) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
        end else if (sck_rise) begin
            rx_q      <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (load_tx) tx_q <= tx_load;
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
            tx_q <= {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_sync) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_CMD;
                S_CMD:    if (byte_done) state_d = rx_byte[7] ? S_WDATA : S_RDUMMY;
                S_RDUMMY: if (byte_done) state_d = S_RDATA;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cmd_done = 1'b0;
        wr_byte  = 1'b0;
        rd_byte  = 1'b0;
        if (byte_done) begin
            case (state_q)
                S_CMD:             cmd_done = 1'b1;
                S_WDATA:           wr_byte  = 1'b1;
                S_RDUMMY, S_RDATA: rd_byte  = 1'b1;
                default:           ;
            endcase
        end
    end

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        hs_read_d  = hs_read_q;
        hs_write_d = hs_write_q;
        hs_addr_d  = hs_addr_q;
        hs_data_d  = hs_data_q;
        addr_d     = addr_q;
        rbuf_d     = rbuf_q;
        rvalid_d   = rvalid_q;
        rd_want_d  = rd_want_q;
        stale_d    = stale_q;
        ovr_d      = 1'b0;
        load_tx    = 1'b0;
        tx_load    = 8'h00;
        wr_go      = 1'b0;
        reload     = 1'b0;
`ifndef SPI_SLV_AUTOINC_EN
        first_d    = first_q;
`endif
        if (busy && hs_ready_i) begin
            hs_read_d  = 1'b0;
            hs_write_d = 1'b0;
            stale_d    = 1'b0;
            if (hs_read_q && !stale_q) begin
                rbuf_d   = hs_data_i;
                rvalid_d = 1'b1;
            end
        end
        if (cs_sync) begin
            rd_want_d = 1'b0;
            rvalid_d  = 1'b0;
            // A read left in flight by an aborted frame must not feed the next frame.
            if (hs_read_q && !hs_ready_i) stale_d = 1'b1;
        end else begin
            if (cmd_done) begin
                addr_d    = rx_byte[ADDR_W-1:0];
                rd_want_d = ~rx_byte[7];
`ifndef SPI_SLV_AUTOINC_EN
                first_d   = 1'b1;
`endif
            end
            if (wr_byte) begin
`ifdef SPI_SLV_AUTOINC_EN
                wr_go  = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
`else
                wr_go   = first_q;
                first_d = 1'b0;
`endif
                if (wr_go) begin
                    if (busy) begin
                        ovr_d = 1'b1;
                    end else begin
                        hs_write_d = 1'b1;
                        hs_addr_d  = addr_q;
                        hs_data_d  = rx_byte;
                    end
                end
            end
            if (rd_byte) begin
                load_tx = 1'b1;
`ifdef SPI_SLV_AUTOINC_EN
                reload    = 1'b1;
                addr_d    = addr_q + ADDR_W'(1);
                rd_want_d = 1'b1;
`else
                reload    = (state_q == S_RDUMMY);
`endif
                if (reload) begin
                    tx_load  = rvalid_q ? rbuf_q : 8'h00;
                    ovr_d    = ~rvalid_q;
                    rvalid_d = 1'b0;
                end
            end
            if (rd_want_d && !busy) begin
                hs_read_d = 1'b1;
                hs_addr_d = addr_d;
                rd_want_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_read_q  <= 1'b0;
            hs_write_q <= 1'b0;
            hs_addr_q  <= '0;
            hs_data_q  <= '0;
            addr_q     <= '0;
            rbuf_q     <= '0;
            rvalid_q   <= 1'b0;
            rd_want_q  <= 1'b0;
            stale_q    <= 1'b0;
            ovr_q      <= 1'b0;
`ifndef SPI_SLV_AUTOINC_EN
            first_q    <= 1'b0;
`endif
        end else begin
            hs_read_q  <= hs_read_d;
            hs_write_q <= hs_write_d;
            hs_addr_q  <= hs_addr_d;
            hs_data_q  <= hs_data_d;
            addr_q     <= addr_d;
            rbuf_q     <= rbuf_d;
            rvalid_q   <= rvalid_d;
            rd_want_q  <= rd_want_d;
            stale_q    <= stale_d;
            ovr_q      <= ovr_d;
`ifndef SPI_SLV_AUTOINC_EN
            first_q    <= first_d;
`endif
        end
    end

    assign miso_o     = ~cs_sync & tx_q[7];
    assign miso_oe_o  = ~cs_sync;
    assign hs_read_o  = hs_read_q;
    assign hs_write_o = hs_write_q;
    assign hs_addr_o  = hs_addr_q;
    assign hs_data_o  = hs_data_q;
    assign ovr_o      = ovr_q;
endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: SPI host tasks, a delayed handshake responder, and logged transactions.
module tb_spi_slv;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_ni, sck, cs_n, mosi;
    logic       miso, miso_oe, hs_read, hs_write, hs_ready, ovr;
    logic [4:0] hs_addr;
    logic [7:0] hs_wdata, hs_rdata;

    int         n_cmp = 0, n_fail = 0;
    int         resp_delay = 3;
    int         ovr_cnt = 0, unstable_cnt = 0;
    logic [4:0] wr_addr_q[$], rd_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] mem [32];

    spi_slv #(.ADDR_W(5), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .sck_i(sck), .cs_ni(cs_n), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .hs_read_o(hs_read), .hs_write_o(hs_write),
        .hs_addr_o(hs_addr), .hs_data_o(hs_wdata), .hs_ready_i(hs_ready),
        .hs_data_i(hs_rdata), .ovr_o(ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Responder: acknowledges each request resp_delay cycles after it appears.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        hs_ready = 1'b0;
        hs_rdata = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
        mem[5] = 8'hC3;
        mem[6] = 8'h3C;
        forever begin
            @(negedge clk);
            if (hs_ready) begin
                hs_ready = 1'b0;
            end else if (hs_read || hs_write) begin
                wait_cnt++;
                if (wait_cnt >= resp_delay) begin
                    hs_ready = 1'b1;
                    wait_cnt = 0;
                    if (hs_write) begin
                        wr_addr_q.push_back(hs_addr);
                        wr_data_q.push_back(hs_wdata);
                    end else begin
                        rd_addr_q.push_back(hs_addr);
                        hs_rdata = mem[hs_addr];
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    logic        prev_req = 1'b0;
    logic [14:0] prev_bus = '0;
    always @(negedge clk) begin
        if (ovr) ovr_cnt++;
        if ((hs_read || hs_write) && prev_req && ({hs_read, hs_write, hs_addr, hs_wdata} != prev_bus))
            unstable_cnt++;
        prev_req = (hs_read || hs_write) && !hs_ready;
        prev_bus = {hs_read, hs_write, hs_addr, hs_wdata};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sck   = 1'b1;
            rx[i] = miso;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((hs_read || hs_write) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(hs_read | hs_write), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        int         wb, rb, ob;
        rst_ni = 1'b0;
        sck    = 1'b0;
        cs_n   = 1'b1;
        mosi   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso",     32'(miso),     32'd0);
        check("rst_miso_oe",  32'(miso_oe),  32'd0);
        check("rst_hs_read",  32'(hs_read),  32'd0);
        check("rst_hs_write", 32'(hs_write), 32'd0);
        check("rst_hs_addr",  32'(hs_addr),  32'd0);
        check("rst_hs_data",  32'(hs_wdata), 32'd0);
        check("rst_ovr",      32'(ovr),      32'd0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);

        // Reset while a write is in flight and a frame is mid-byte.
        resp_delay = 500;
        wb = wr_addr_q.size();
        cs_lo();
        spi_bits(8'h83, 8, rx);
        spi_bits(8'h5A, 8, rx);
        repeat (4) @(negedge clk);
        check("t1_wr_pending", 32'(hs_write), 32'd1);
        check("t1_oe_active",  32'(miso_oe),  32'd1);
        spi_bits(8'h00, 4, rx);
        rst_ni = 1'b0;
        #1;
        check("t1_rst_write", 32'(hs_write), 32'd0);
        check("t1_rst_oe",    32'(miso_oe),  32'd0);
        check("t1_rst_addr",  32'(hs_addr),  32'd0);
        check("t1_rst_data",  32'(hs_wdata), 32'd0);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_ni = 1'b1;
        resp_delay = 3;
        repeat (20) @(negedge clk);
        check("t1_no_req", 32'(hs_read | hs_write), 32'd0);
        check("t1_no_wr",  32'(wr_addr_q.size() - wb), 32'd0);

        // Single write.
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); ob = ovr_cnt;
        cs_lo();
        spi_bits(8'h83, 8, rx);
        spi_bits(8'h5A, 8, rx);
        cs_hi();
        wait_idle("t2_idle");
        check("t2_wr_cnt",  32'(wr_addr_q.size() - wb), 32'd1);
        check("t2_wr_addr", 32'(wr_addr_q[wb]), 32'd3);
        check("t2_wr_data", 32'(wr_data_q[wb]), 32'h5A);
        check("t2_rd_cnt",  32'(rd_addr_q.size() - rb), 32'd0);
        check("t2_ovr",     32'(ovr_cnt - ob), 32'd0);

        // Read with responder ready in 4 cycles.
        resp_delay = 4;
        rb = rd_addr_q.size(); ob = ovr_cnt;
        cs_lo();
        spi_bits(8'h05, 8, rx);
        check("t3_cmd_miso", 32'(rx), 32'h00);
        spi_bits(8'h00, 8, rx);
        check("t3_dummy_miso", 32'(rx), 32'h00);
        spi_bits(8'h00, 8, rx);
        check("t3_data_miso", 32'(rx), 32'hC3);
        cs_hi();
        wait_idle("t3_idle");
        check("t3_rd_addr", 32'(rd_addr_q[rb]), 32'd5);
        check("t3_ovr",     32'(ovr_cnt - ob), 32'd0);
`ifdef SPI_SLV_AUTOINC_EN
        check("t3_rd_cnt", 32'(rd_addr_q.size() - rb), 32'd3);
`else
        check("t3_rd_cnt", 32'(rd_addr_q.size() - rb), 32'd1);
`endif

        // Read whose data arrives after the dummy byte.
        resp_delay = 200;
        rb = rd_addr_q.size(); ob = ovr_cnt;
        cs_lo();
        spi_bits(8'h06, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("t4_late_miso", 32'(rx), 32'h00);
        cs_hi();
        check("t4_ovr_once", 32'(ovr_cnt - ob), 32'd1);
        wait_idle("t4_idle");
        check("t4_rd_addr", 32'(rd_addr_q[rb]), 32'd6);

        // Write burst starting at the top address.
        resp_delay = 3;
        wb = wr_addr_q.size(); ob = ovr_cnt;
        cs_lo();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        cs_hi();
        wait_idle("t5_idle");
        check("t5_wr0_addr", 32'(wr_addr_q[wb]), 32'd31);
        check("t5_wr0_data", 32'(wr_data_q[wb]), 32'h11);
        check("t5_ovr",      32'(ovr_cnt - ob), 32'd0);
`ifdef SPI_SLV_AUTOINC_EN
        check("t5_wr_cnt",   32'(wr_addr_q.size() - wb), 32'd2);
        check("t5_wr1_addr", 32'(wr_addr_q[wb + 1]), 32'd0);
        check("t5_wr1_data", 32'(wr_data_q[wb + 1]), 32'h22);
`else
        check("t5_wr_cnt",   32'(wr_addr_q.size() - wb), 32'd1);
`endif

        // Frame aborted after 4 bits of the data byte, then a clean frame.
        wb = wr_addr_q.size(); ob = ovr_cnt;
        cs_lo();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h77, 4, rx);
        cs_hi();
        wait_idle("t6_abort_idle");
        check("t6_abort_wr", 32'(wr_addr_q.size() - wb), 32'd0);
        check("t6_abort_ovr", 32'(ovr_cnt - ob), 32'd0);
        cs_lo();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h77, 8, rx);
        cs_hi();
        wait_idle("t6_idle");
        check("t6_wr_cnt",  32'(wr_addr_q.size() - wb), 32'd1);
        check("t6_wr_addr", 32'(wr_addr_q[wb]), 32'd1);
        check("t6_wr_data", 32'(wr_data_q[wb]), 32'h77);

        check("hs_stable", 32'(unstable_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
